// File: rtl/mem_port_arbiter.sv
// Two-port arbiter merging the fetch read port and the data read/write port onto
// the single request interface of mem_system, with anti-starvation and statistics.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rd,
   input  logic [15:0] i_addr,
   output logic [15:0] i_data,
   output logic        i_done,
   output logic        i_stall,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_data,
   output logic        d_done,
   output logic        d_stall,
   output logic [15:0] m_addr,
   output logic [15:0] m_datain,
   output logic        m_rd,
   output logic        m_wr,
   input  logic [15:0] m_dataout,
   input  logic        m_done,
   input  logic        m_stall,
   input  logic        m_hit,
   input  logic        m_err,
   output logic        err,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [15:0] gaddr_q, gaddr_d, gdata_q, gdata_d;
   logic        grd_q, grd_d, gwr_q, gwr_d;
   logic [15:0] ihold_q, dhold_q, hit_q, miss_q;
   logic        err_q;

   logic        own_i, own_d, ill, d_req;
   logic        mrd, mwr;
   logic [15:0] maddr, mdin;
   logic        d_rd_cmp;

   // Completion is defined solely by m_done; Stall is only informational.
   wire unused_m_stall = m_stall;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      gaddr_d  = gaddr_q;
      gdata_d  = gdata_q;
      grd_d    = grd_q;
      gwr_d    = gwr_q;
      own_i    = 1'b0;
      own_d    = 1'b0;
      ill      = 1'b0;
      d_req    = 1'b0;
      mrd      = 1'b0;
      mwr      = 1'b0;
      maddr    = 16'h0000;
      mdin     = 16'h0000;
      case (state_q)
         IDLE: begin
            ill   = d_rd & d_wr;
            d_req = d_rd ^ d_wr;
            // Data wins unless fetch has waited through STARVE_LIMIT data grants.
            if (d_req && !(i_rd && starve_q == LIMIT)) begin
               own_d   = 1'b1;
               gaddr_d = d_addr;
               gdata_d = d_wdata;
               grd_d   = d_rd;
               gwr_d   = d_wr;
               if (!m_done) state_d = BUSY_D;
               if (i_rd && starve_q != 4'hF) starve_d = starve_q + 4'd1;
            end else if (i_rd) begin
               own_i    = 1'b1;
               gaddr_d  = i_addr;
               gdata_d  = 16'h0000;
               grd_d    = 1'b1;
               gwr_d    = 1'b0;
               starve_d = 4'd0;
               if (!m_done) state_d = BUSY_I;
            end
            if (own_i || own_d) begin
               mrd   = grd_d;
               mwr   = gwr_d;
               maddr = gaddr_d;
               mdin  = gdata_d;
            end
         end
         BUSY_I, BUSY_D: begin
            own_i = (state_q == BUSY_I);
            own_d = (state_q == BUSY_D);
            mrd   = grd_q;
            mwr   = gwr_q;
            maddr = gaddr_q;
            mdin  = gdata_q;
            if (m_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!i_rd) starve_d = 4'd0;
   end

   // Everything visible to mem_system and the requesters is forced quiet in reset.
   assign m_rd     = rst & mrd;
   assign m_wr     = rst & mwr;
   assign m_addr   = rst ? maddr : 16'h0000;
   assign m_datain = rst ? mdin : 16'h0000;
   assign i_done   = rst & m_done & own_i;
   assign d_done   = rst & ((m_done & own_d) | ill);
   assign d_rd_cmp = rst & m_done & own_d & mrd;
   assign i_stall  = rst & i_rd & ~i_done;
   assign d_stall  = rst & (d_rd | d_wr) & ~d_done;
   assign i_data   = i_done ? m_dataout : ihold_q;
   assign d_data   = d_rd_cmp ? m_dataout : dhold_q;
   assign err      = err_q;
   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         starve_q <= 4'd0;
         gaddr_q  <= 16'h0000;
         gdata_q  <= 16'h0000;
         grd_q    <= 1'b0;
         gwr_q    <= 1'b0;
         ihold_q  <= 16'h0000;
         dhold_q  <= 16'h0000;
         hit_q    <= 16'h0000;
         miss_q   <= 16'h0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         gaddr_q  <= gaddr_d;
         gdata_q  <= gdata_d;
         grd_q    <= grd_d;
         gwr_q    <= gwr_d;
         if (i_done)   ihold_q <= m_dataout;
         if (d_rd_cmp) dhold_q <= m_dataout;
         if (ill || (m_err && (mrd || mwr))) err_q <= 1'b1;
         if (m_done) begin
            if (m_hit) begin
               if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else begin
               if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well clear of the rising edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rd, d_rd, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata, m_dataout;
   logic        m_done, m_stall, m_hit, m_err;
   logic [15:0] i_data, d_data, m_addr, m_datain, hit_cnt, miss_cnt;
   logic        i_done, i_stall, d_done, d_stall, m_rd, m_wr, err;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_stall(i_stall),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_data(d_data),
      .d_done(d_done), .d_stall(d_stall),
      .m_addr(m_addr), .m_datain(m_datain), .m_rd(m_rd), .m_wr(m_wr),
      .m_dataout(m_dataout), .m_done(m_done), .m_stall(m_stall), .m_hit(m_hit), .m_err(m_err),
      .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_rd = 0; d_rd = 0; d_wr = 0; m_done = 0; m_hit = 0; m_err = 0; m_stall = 0;
   endtask

   initial begin
      rst = 0; i_addr = 0; d_addr = 0; d_wdata = 0; m_dataout = 0;
      idle_inputs();
      i_rd = 1; d_rd = 1; i_addr = 16'h1111; d_addr = 16'h2222;
      step(); #1;
      chk("rst_m_rd", {15'd0, m_rd}, 16'd0);
      chk("rst_m_addr", m_addr, 16'h0000);
      chk("rst_i_stall", {15'd0, i_stall}, 16'd0);
      chk("rst_d_stall", {15'd0, d_stall}, 16'd0);
      chk("rst_hit", hit_cnt, 16'd0);
      chk("rst_miss", miss_cnt, 16'd0);
      chk("rst_err", {15'd0, err}, 16'd0);
      chk("rst_i_data", i_data, 16'h0000);
      step(); idle_inputs(); rst = 1;

      // Fetch-only hit
      step(); i_rd = 1; i_addr = 16'h0040; m_done = 1; m_hit = 1; m_dataout = 16'h1234; #1;
      chk("fh_m_rd", {15'd0, m_rd}, 16'd1);
      chk("fh_m_addr", m_addr, 16'h0040);
      chk("fh_i_done", {15'd0, i_done}, 16'd1);
      chk("fh_i_data", i_data, 16'h1234);
      chk("fh_i_stall", {15'd0, i_stall}, 16'd0);
      step(); idle_inputs(); m_dataout = 16'h9999; #1;
      chk("fh_hit_cnt", hit_cnt, 16'd1);
      chk("fh_idle_m_rd", {15'd0, m_rd}, 16'd0);
      chk("fh_i_data_hold", i_data, 16'h1234);

      // Data write miss, done on the sixth cycle
      for (int c = 1; c <= 6; c++) begin
         step(); d_wr = 1; d_addr = 16'h0A00; d_wdata = 16'hBEEF;
         m_done = (c == 6); m_hit = 0; #1;
         chk($sformatf("wm_m_wr_c%0d", c), {15'd0, m_wr}, 16'd1);
         chk($sformatf("wm_m_addr_c%0d", c), m_addr, 16'h0A00);
         chk($sformatf("wm_m_datain_c%0d", c), m_datain, 16'hBEEF);
         chk($sformatf("wm_d_stall_c%0d", c), {15'd0, d_stall}, (c == 6) ? 16'd0 : 16'd1);
         chk($sformatf("wm_d_done_c%0d", c), {15'd0, d_done}, (c == 6) ? 16'd1 : 16'd0);
      end
      step(); idle_inputs(); #1;
      chk("wm_miss_cnt", miss_cnt, 16'd1);
      chk("wm_d_data_unchanged", d_data, 16'h0000);
      chk("wm_err_clear", {15'd0, err}, 16'd0);

      // Contention, all hits: D,D,D,D,I,D,D,D,D,I
      for (int k = 0; k < 10; k++) begin
         step(); i_rd = 1; i_addr = 16'h1000; d_rd = 1; d_addr = 16'h2000;
         m_done = 1; m_hit = 1; m_dataout = 16'h5000 + 16'(k); #1;
         chk($sformatf("ct_m_addr_%0d", k), m_addr, (k % 5 == 4) ? 16'h1000 : 16'h2000);
         chk($sformatf("ct_i_stall_%0d", k), {15'd0, i_stall}, (k % 5 == 4) ? 16'd0 : 16'd1);
         chk($sformatf("ct_d_done_%0d", k), {15'd0, d_done}, (k % 5 == 4) ? 16'd0 : 16'd1);
      end
      step(); idle_inputs(); #1;
      chk("ct_hit_cnt", hit_cnt, 16'd11);
      chk("ct_d_data", d_data, 16'h5008);
      chk("ct_i_data", i_data, 16'h5009);

      // m_err during a BUSY_D read
      step(); d_rd = 1; d_addr = 16'h0300; #1;
      chk("me_issue_m_rd", {15'd0, m_rd}, 16'd1);
      step(); m_err = 1; #1;
      chk("me_busy_d_done", {15'd0, d_done}, 16'd0);
      chk("me_busy_m_addr", m_addr, 16'h0300);
      step(); m_err = 0; m_done = 1; m_hit = 0; m_dataout = 16'h7777; #1;
      chk("me_d_done", {15'd0, d_done}, 16'd1);
      chk("me_d_data", d_data, 16'h7777);
      chk("me_err_set", {15'd0, err}, 16'd1);
      step(); idle_inputs(); m_dataout = 16'h0000; #1;
      chk("me_d_data_hold", d_data, 16'h7777);
      chk("me_miss_cnt", miss_cnt, 16'd2);

      // Reset two cycles into BUSY_I
      step(); i_rd = 1; i_addr = 16'h0080; #1;
      chk("rm_issue", {15'd0, m_rd}, 16'd1);
      step(); #1;
      step(); #1;
      chk("rm_busy_i_stall", {15'd0, i_stall}, 16'd1);
      #1 rst = 0; #1;
      chk("rm_m_rd", {15'd0, m_rd}, 16'd0);
      chk("rm_i_stall", {15'd0, i_stall}, 16'd0);
      chk("rm_hit", hit_cnt, 16'd0);
      chk("rm_miss", miss_cnt, 16'd0);
      chk("rm_err", {15'd0, err}, 16'd0);
      step(); i_rd = 0; rst = 1;
      step(); i_rd = 1; i_addr = 16'h00C0; m_done = 1; m_hit = 1; m_dataout = 16'h4321; #1;
      chk("rm_new_m_rd", {15'd0, m_rd}, 16'd1);
      chk("rm_new_m_addr", m_addr, 16'h00C0);
      chk("rm_new_i_done", {15'd0, i_done}, 16'd1);
      chk("rm_new_i_data", i_data, 16'h4321);

      // Illegal d_rd & d_wr
      step(); idle_inputs(); d_rd = 1; d_wr = 1; d_addr = 16'h0500; m_dataout = 16'hDEAD; #1;
      chk("il_m_rd", {15'd0, m_rd}, 16'd0);
      chk("il_m_wr", {15'd0, m_wr}, 16'd0);
      chk("il_d_done", {15'd0, d_done}, 16'd1);
      chk("il_d_data", d_data, 16'h0000);
      chk("il_err_not_yet", {15'd0, err}, 16'd0);
      step(); idle_inputs(); #1;
      chk("il_err_next", {15'd0, err}, 16'd1);
      step(); #1;
      chk("il_err_sticky", {15'd0, err}, 16'd1);
      chk("il_i_data_hold", i_data, 16'h4321);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port request arbiter that sits directly upstream of `mem_system`. It merges the fetch-stage read port and the memory-stage read/write port onto the single `Addr/DataIn/Rd/Wr` request interface of the cache memory system. It holds each granted request stable until the memory system reports `Done`. It returns data and completion to the owning requester, prevents fetch starvation, and keeps sticky error and hit/miss statistics.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data-port grants while a fetch request is waiting; range 1–15.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `i_rd` in 1: fetch read request, held until `i_done`.
- `i_addr` in 16: fetch address.
- `i_data` out 16: fetch read data.
- `i_done` out 1: fetch completion pulse.
- `i_stall` out 1: fetch request pending and not done.
- `d_rd`, `d_wr` in 1 each: data read/write request, held until `d_done`.
- `d_addr` in 16: data address.
- `d_wdata` in 16: data write data.
- `d_data` out 16: data read data.
- `d_done` out 1: data completion pulse.
- `d_stall` out 1: data request pending and not done.
- `m_addr`, `m_datain` out 16 each: drive `mem_system` `Addr`/`DataIn`.
- `m_rd`, `m_wr` out 1 each: drive `mem_system` `Rd`/`Wr`.
- `m_dataout` in 16: from `mem_system` `DataOut`.
- `m_done`, `m_stall`, `m_hit`, `m_err` in 1 each: from `mem_system` `Done`/`Stall`/`CacheHit`/`err`.
- `err` out 1: sticky error.
- `hit_cnt`, `miss_cnt` out 16 each: saturating access statistics.

## Operation
- States:
  - IDLE: no outstanding request.
  - BUSY_I: fetch request outstanding.
  - BUSY_D: data request outstanding.
- Issue in IDLE is combinational (zero-latency). The winner's address, data and `m_rd`/`m_wr` drive the memory system in the same cycle. Winner fields are also captured into grant registers.
- Arbitration: the data port wins by default. The fetch port wins instead when `i_rd` is high, a data request is present, and `starve_cnt == STARVE_LIMIT`. With only one request present, that request wins.
- `starve_cnt` (4 bits):
  - Increments on each data grant made while `i_rd` is high.
  - Clears on a fetch grant, or on any cycle where `i_rd` is low.
- On `m_done` in the issue cycle (hit): stay in IDLE.
- On no `m_done` in the issue cycle: go to BUSY_x.
- In BUSY_x:
  - `m_addr`, `m_datain`, `m_rd`, `m_wr` come from the grant registers.
  - They are held constant until and including the `m_done` cycle; the state then returns to IDLE.
  - Requester inputs are ignored for the other port. The other port's stall stays high if it is requesting.
- Completion:
  - `x_done = m_done & (owner == x)`, combinational.
  - `x_data = m_dataout` in the done cycle; otherwise the last value captured for that port. Each port has its own 16-bit holding register, loaded only on its read completions.
  - A write completion leaves `d_data` unchanged.
- A request still asserted in the cycle after its done is a new request.
- `x_stall = request & ~x_done`.
- Illegal `d_rd & d_wr` together:
  - No memory access; `err` sets.
  - `d_done` pulses the same cycle and `d_data` holds.
  - The fetch port may be granted in that cycle.
- Errors: `m_err` high in any cycle with `m_rd|m_wr` high sets `err`. `err` clears only on reset.
- Statistics: on each `m_done`, `hit_cnt` increments if `m_hit`, else `miss_cnt` increments. Both saturate at 16'hFFFF.

## Timing
- Reset values:
  - State IDLE.
  - `starve_cnt`, holding registers, `hit_cnt`, `miss_cnt` = 0.
  - `err` = 0.
  - `m_rd`, `m_wr`, `i_done`, `d_done`, `i_stall`, `d_stall` forced 0 while `rst` is low.
  - `m_addr`/`m_datain` = 0 while `rst` is low.
- Reset mid-transaction aborts it immediately, and no done is produced. Requesters must re-issue after reset deasserts.
- Hit latency: 1 cycle (issue and done in the same cycle).
- Miss latency: `mem_system` latency, with no added arbiter cycles.
- After a BUSY completion, the next grant occurs in the following IDLE cycle, so there is one-cycle spacing.
- After an IDLE-cycle hit, back-to-back issue is possible every cycle.
- `m_stall` is informational only. Completion is defined solely by `m_done`.

## Test plan
- Fetch-only hit: `i_rd=1`, `i_addr=16'h0040`, `m_done`=1 in the same cycle with `m_dataout=16'h1234`.
  - Required: `i_done=1` and `i_data=16'h1234` that cycle, state IDLE, `hit_cnt=1`.
- Data write miss: `d_wr=1`, `d_addr=16'h0A00`, `d_wdata=16'hBEEF`, `m_done` arriving 5 cycles later.
  - Required: `m_wr`/`m_addr`/`m_datain` constant for 6 cycles, `d_stall=1` for 5 cycles, `d_done` on cycle 6, `miss_cnt=1`.
- Contention with `STARVE_LIMIT=4`: `i_rd` and `d_rd` held continuously, every access a hit.
  - Required grant sequence D,D,D,D,I,D,D,D,D,I…
  - Required: `i_stall` high exactly 4 cycles before each fetch grant.
- Illegal `d_rd=d_wr=1`.
  - Required: `m_rd=m_wr=0`, `d_done=1`, `err=1` the next cycle and sticky thereafter.
- `m_err=1` during a BUSY_D read.
  - Required: `err` sets; the transaction still completes on `m_done`.
- Reset mid-miss: `rst`=0 two cycles into BUSY_I.
  - Required: `m_rd=0` and `i_stall=0` asynchronously, counters 0.
  - Required: a new `i_rd` after reset is issued normally.
